// File: rtl/vga_timing.sv
// Raster timing generator for 640x480@60 VGA: pixel coordinates, active flag and active-low syncs, all registered and aligned.
// Latency one enabled cycle from counter to outputs; en low freezes all state. Optional frame counter: VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk_25,
    input  logic        rst_n,
    input  logic        en,
    output logic [9:0]  sx,
    output logic [9:0]  sy,
    output logic        active_pixel,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hc;
    logic [9:0] vc;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
        end
    end

    // Outputs are decoded from the pre-increment counters so every output describes the same pixel.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            sx           <= '0;
            sy           <= '0;
            active_pixel <= 1'b0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (en) begin
            sx           <= hc;
            sy           <= vc;
            active_pixel <= (hc < H_ACT) && (vc < V_ACT);
            hsync        <= !((hc >= HS_BEG) && (hc < HS_END));
            vsync        <= !((vc >= VS_BEG) && (vc < VS_END));
            line_start   <= (hc == 10'd0);
            frame_start  <= (hc == 10'd0) && (vc == 10'd0);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // The frame start loaded on the first edge after reset opens frame 0, it does not complete one.
    logic        first_done;
    logic [15:0] fcnt;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            first_done <= 1'b0;
            fcnt       <= '0;
        end else if (en) begin
            first_done <= 1'b1;
            if (first_done && (hc == 10'd0) && (vc == 10'd0))
                fcnt <= fcnt + 16'd1;
        end
    end

    assign frame_cnt = fcnt;
`else
    assign frame_cnt = '0;
`endif

endmodule
